// File: rtl/jtag_frame_master.sv
// Host-side JTAG initiator: TAP reset, one IR load, then one 11-bit {data, addr} DR scan per request.
// Latency: a request accepted on clock T gives rsp_valid_o on T+1+32*CLK_DIV; init takes (12+IR_LEN)*2*CLK_DIV clocks.
// Backpressure: req_ready_o is high only in IDLE; a request is held off while a scan or init walk is in flight.
module jtag_frame_master #(
  parameter int                CLK_DIV  = 4,
  parameter int                IR_LEN   = 6,
  parameter logic [IR_LEN-1:0] IR_VALUE = IR_LEN'(2)
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic [7:0] req_data_i,
  input  logic [2:0] req_addr_i,
  output logic       rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic [2:0] rsp_addr_o,
  input  logic       reinit_i,
  output logic       init_done_o,
  output logic       tck_o,
  output logic       tms_o,
  output logic       tdi_o,
  input  logic       tdo_i
);

  localparam int PH_W  = $clog2(2 * CLK_DIV);
  localparam int IDX_W = $clog2(IR_LEN + 17);
  localparam int IRB_W = (IR_LEN > 1) ? $clog2(IR_LEN) : 1;

  // Phase counter: low half is 0..CLK_DIV-1, high half is CLK_DIV..2*CLK_DIV-1.
  localparam logic [PH_W-1:0]  PH_LAST     = PH_W'(2 * CLK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_HIGH     = PH_W'(CLK_DIV);

  // Slot indices within each state's TMS walk.
  localparam logic [IDX_W-1:0] TLR_LAST    = IDX_W'(5);
  localparam logic [IDX_W-1:0] IR_SH_FIRST = IDX_W'(4);
  localparam logic [IDX_W-1:0] IR_SH_LAST  = IDX_W'(IR_LEN + 3);
  localparam logic [IDX_W-1:0] IR_UPD      = IDX_W'(IR_LEN + 4);
  localparam logic [IDX_W-1:0] IR_LAST     = IDX_W'(IR_LEN + 5);
  localparam logic [IDX_W-1:0] DR_SH_FIRST = IDX_W'(3);
  localparam logic [IDX_W-1:0] DR_SH_LAST  = IDX_W'(13);
  localparam logic [IDX_W-1:0] DR_UPD      = IDX_W'(14);
  localparam logic [IDX_W-1:0] DR_LAST     = IDX_W'(15);

  typedef enum logic [1:0] {
    INIT_TLR,
    INIT_IR,
    IDLE,
    DR_SCAN
  } state_t;

  state_t             state, state_nxt;
  logic [IDX_W-1:0]   idx, idx_nxt, last_idx;
  logic [PH_W-1:0]    ph, ph_nxt;
  logic               slot_end, last_slot, new_slot, accept, samp;
  logic               tms_nxt, tdi_nxt;
  logic [IRB_W-1:0]   ir_sel;
  logic [3:0]         fr_sel, rx_sel;
  logic [10:0]        frame, rx;

  assign req_ready_o = (state == IDLE);

  // State, slot index and phase counter registers; reset parks at the first TLR slot.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= INIT_TLR;
      idx   <= '0;
      ph    <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      ph    <= ph_nxt;
    end
  end

  // Next state, slot sequencing and the TMS/TDI bits for the slot about to start.
  always_comb begin
    last_idx  = DR_LAST;
    state_nxt = state;
    tms_nxt   = 1'b0;
    tdi_nxt   = 1'b0;

    case (state)
      INIT_TLR: last_idx = TLR_LAST;
      INIT_IR:  last_idx = IR_LAST;
      default:  last_idx = DR_LAST;
    endcase

    slot_end  = (state != IDLE) && (ph == PH_LAST);
    last_slot = slot_end && (idx == last_idx);
    accept    = (state == IDLE) && req_valid_i && !reinit_i;

    case (state)
      INIT_TLR: if (last_slot) state_nxt = INIT_IR;
      INIT_IR:  if (last_slot) state_nxt = IDLE;
      IDLE: begin
        if (reinit_i)         state_nxt = INIT_TLR;
        else if (req_valid_i) state_nxt = DR_SCAN;
      end
      DR_SCAN:  if (last_slot) state_nxt = IDLE;
      default:  state_nxt = INIT_TLR;
    endcase

    if (state_nxt != state) idx_nxt = '0;
    else if (slot_end)      idx_nxt = idx + IDX_W'(1);
    else                    idx_nxt = idx;

    if (state_nxt == IDLE || state == IDLE || slot_end) ph_nxt = '0;
    else                                               ph_nxt = ph + PH_W'(1);

    new_slot = slot_end || ((state == IDLE) && (state_nxt != IDLE));

    ir_sel = IRB_W'(idx_nxt - IR_SH_FIRST);
    fr_sel = 4'(idx_nxt - DR_SH_FIRST);
    rx_sel = 4'(idx - DR_SH_FIRST);
    samp   = (state == DR_SCAN) && (ph == PH_LAST) &&
             (idx >= DR_SH_FIRST) && (idx <= DR_SH_LAST);

    case (state_nxt)
      INIT_TLR: tms_nxt = (idx_nxt != TLR_LAST);
      INIT_IR: begin
        tms_nxt = (idx_nxt < IDX_W'(2)) || (idx_nxt == IR_SH_LAST) || (idx_nxt == IR_UPD);
        if (idx_nxt >= IR_SH_FIRST && idx_nxt <= IR_SH_LAST) tdi_nxt = IR_VALUE[ir_sel];
      end
      DR_SCAN: begin
        tms_nxt = (idx_nxt == '0) || (idx_nxt == DR_SH_LAST) || (idx_nxt == DR_UPD);
        if (idx_nxt >= DR_SH_FIRST && idx_nxt <= DR_SH_LAST) tdi_nxt = frame[fr_sel];
      end
      default: ;
    endcase
  end

  // JTAG pins, frame/capture registers and response/init status.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tck_o       <= 1'b0;
      tms_o       <= 1'b1;
      tdi_o       <= 1'b0;
      frame       <= '0;
      rx          <= '0;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_addr_o  <= '0;
      init_done_o <= 1'b0;
    end else begin
      rsp_valid_o <= 1'b0;
      tck_o       <= (state_nxt != IDLE) && (ph_nxt >= PH_HIGH);
      if (state_nxt == IDLE) begin
        tms_o <= 1'b0;
        tdi_o <= 1'b0;
      end else if (new_slot) begin
        tms_o <= tms_nxt;
        tdi_o <= tdi_nxt;
      end
      if (accept) frame <= {req_data_i, req_addr_i};
      if (samp) rx[rx_sel] <= tdo_i;
      if (state == INIT_IR && last_slot) init_done_o <= 1'b1;
      if (state == IDLE && reinit_i) init_done_o <= 1'b0;
      if (state == DR_SCAN && last_slot) begin
        rsp_valid_o <= 1'b1;
        rsp_data_o  <= rx[10:3];
        rsp_addr_o  <= rx[2:0];
      end
    end
  end

endmodule

// File: tb/tb_jtag_frame_master.sv
// Self-checking bench: two masters (CLK_DIV=4 and CLK_DIV=1), each driving a behavioural TAP with an 11-bit user DR.
// Latency: checks init, frame and reinit timing in clock counts.
// Backpressure: exercises back-to-back requests and reinit racing a pending request.
module tb_jtag_frame_master;

  localparam logic [3:0] TLR = 4'd0, RTI = 4'd1, SELDR = 4'd2, CAPDR = 4'd3, SHDR = 4'd4,
                         EX1DR = 4'd5, PAUDR = 4'd6, EX2DR = 4'd7, UPDR = 4'd8, SELIR = 4'd9,
                         CAPIR = 4'd10, SHIR = 4'd11, EX1IR = 4'd12, PAUIR = 4'd13, EX2IR = 4'd14,
                         UPIR = 4'd15;
  localparam logic [17:0] INIT_TMS = 18'b111110110000000110;
  localparam logic [15:0] DR_TMS   = 16'b1000000000000110;

  typedef struct packed {
    logic [7:0] d;
    logic [2:0] a;
  } rsp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid0, req_valid1, reinit0, reinit1;
  logic [7:0] req_data0, req_data1;
  logic [2:0] req_addr0, req_addr1;
  logic       req_ready0, req_ready1, rsp_valid0, rsp_valid1, init_done0, init_done1;
  logic [7:0] rsp_data0, rsp_data1;
  logic [2:0] rsp_addr0, rsp_addr1;
  wire  [1:0] tck_v, tms_v, tdi_v, tdo_v;
  logic [10:0] cap_v [2];

  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   tms_hist[$];
  bit   tdi_hist[$];
  rsp_t exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  jtag_frame_master #(.CLK_DIV(4)) dut0 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid0), .req_ready_o(req_ready0),
    .req_data_i(req_data0), .req_addr_i(req_addr0), .rsp_valid_o(rsp_valid0),
    .rsp_data_o(rsp_data0), .rsp_addr_o(rsp_addr0), .reinit_i(reinit0),
    .init_done_o(init_done0), .tck_o(tck_v[0]), .tms_o(tms_v[0]), .tdi_o(tdi_v[0]),
    .tdo_i(tdo_v[0])
  );

  jtag_frame_master #(.CLK_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .req_valid_i(req_valid1), .req_ready_o(req_ready1),
    .req_data_i(req_data1), .req_addr_i(req_addr1), .rsp_valid_o(rsp_valid1),
    .rsp_data_o(rsp_data1), .rsp_addr_o(rsp_addr1), .reinit_i(reinit1),
    .init_done_o(init_done1), .tck_o(tck_v[1]), .tms_o(tms_v[1]), .tdi_o(tdi_v[1]),
    .tdo_i(tdo_v[1])
  );

  function automatic logic [3:0] tap_next(input logic [3:0] s, input logic t);
    case (s)
      TLR:     return t ? TLR   : RTI;
      RTI:     return t ? SELDR : RTI;
      SELDR:   return t ? SELIR : CAPDR;
      CAPDR:   return t ? EX1DR : SHDR;
      SHDR:    return t ? EX1DR : SHDR;
      EX1DR:   return t ? UPDR  : PAUDR;
      PAUDR:   return t ? EX2DR : PAUDR;
      EX2DR:   return t ? UPDR  : SHDR;
      UPDR:    return t ? SELDR : RTI;
      SELIR:   return t ? TLR   : CAPIR;
      CAPIR:   return t ? EX1IR : SHIR;
      SHIR:    return t ? EX1IR : SHIR;
      EX1IR:   return t ? UPIR  : PAUIR;
      PAUIR:   return t ? EX2IR : PAUIR;
      EX2IR:   return t ? UPIR  : SHIR;
      default: return t ? SELDR : RTI;
    endcase
  endfunction

  // Behavioural TAP per master: user DR captures cap_v only when IR holds USER1.
  for (genvar g = 0; g < 2; g++) begin : tap
    logic [3:0]  st    = TLR;
    logic [10:0] dr    = '0;
    logic [10:0] upd   = '0;
    logic [5:0]  irs   = '0;
    logic [5:0]  ir    = '1;
    logic        tdo_r = 1'b0;
    assign tdo_v[g] = tdo_r;

    always @(posedge tck_v[g]) begin
      case (st)
        TLR:   ir  <= '1;
        CAPDR: if (ir == 6'h02) dr <= cap_v[g];
        SHDR:  dr  <= {tdi_v[g], dr[10:1]};
        UPDR:  upd <= dr;
        CAPIR: irs <= 6'b000001;
        SHIR:  irs <= {tdi_v[g], irs[5:1]};
        UPIR:  ir  <= irs;
        default: ;
      endcase
      st <= tap_next(st, tms_v[g]);
    end

    always @(negedge tck_v[g]) tdo_r <= (st == SHDR) ? dr[0] : ((st == SHIR) ? irs[0] : 1'b0);
  end

  always @(posedge tck_v[0]) begin
    tms_hist.push_back(tms_v[0]);
    tdi_hist.push_back(tdi_v[0]);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] tms_pack(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v = {v[30:0], tms_hist[base + i]};
    return v;
  endfunction

  function automatic logic [31:0] tdi_pack(input int base, input int n);
    logic [31:0] v;
    v = '0;
    for (int k = 0; k < n; k++) v[k] = tdi_hist[base + k];
    return v;
  endfunction

  task automatic push_exp(input logic [10:0] cap);
    rsp_t e;
    e.d = cap[10:3];
    e.a = cap[2:0];
    exp_q.push_back(e);
  endtask

  task automatic check_rsp(input int which);
    rsp_t e;
    chk("rsp_queue_nonempty", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("rsp_data", which == 1 ? rsp_data1 : rsp_data0, e.d);
      chk("rsp_addr", which == 1 ? rsp_addr1 : rsp_addr0, e.a);
    end
  endtask

  // which: 0 = init_done0, 1 = rsp_valid0, 2 = rsp_valid1
  task automatic wait_flag(input int which, input int bound, output bit hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clk);
      case (which)
        0:       hit = init_done0;
        1:       hit = rsp_valid0;
        default: hit = rsp_valid1;
      endcase
      if (hit) break;
    end
  endtask

  task automatic chk_reset_vals();
    chk("rst_tck", tck_v[0], 0);
    chk("rst_tms", tms_v[0], 1);
    chk("rst_tdi", tdi_v[0], 0);
    chk("rst_ready", req_ready0, 0);
    chk("rst_rsp_valid", rsp_valid0, 0);
    chk("rst_rsp_data", rsp_data0, 0);
    chk("rst_rsp_addr", rsp_addr0, 0);
    chk("rst_init_done", init_done0, 0);
  endtask

  initial begin
    bit hit;
    int t0, t1, h, rel;
    logic [7:0] pat;

    rst = 1'b1;
    req_valid0 = 1'b0; req_valid1 = 1'b0; reinit0 = 1'b0; reinit1 = 1'b0;
    req_data0 = '0; req_addr0 = '0; req_data1 = '0; req_addr1 = '0;
    cap_v[0] = '0; cap_v[1] = '0;
    repeat (3) @(negedge clk);
    chk_reset_vals();

    // Init walk after reset release
    rst = 1'b0;
    rel = cyc;
    wait_flag(0, 400, hit);
    chk("init_seen", hit, 1);
    chk("init_latency", cyc - rel, 144);
    chk("init_slots", tms_hist.size(), 18);
    chk("init_tms", tms_pack(0, 18), INIT_TMS);
    chk("init_ir_tdi", tdi_pack(10, 6), 6'h02);
    chk("init_tap_ir", tap[0].ir, 6'h02);
    chk("init_tap_rti", tap[0].st, RTI);
    chk("init_ready", req_ready0, 1);

    // Single frame
    cap_v[0] = 11'h52B;
    h = tms_hist.size();
    req_valid0 = 1'b1; req_data0 = 8'hA5; req_addr0 = 3'h5;
    push_exp(cap_v[0]);
    t0 = cyc;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("single_ready_drop", req_ready0, 0);
    wait_flag(1, 300, hit);
    chk("single_rsp_seen", hit, 1);
    chk("single_latency", cyc - t0, 129);
    chk("single_ready_at_rsp", req_ready0, 1);
    check_rsp(0);
    chk("single_tms", tms_pack(h, 16), DR_TMS);
    chk("single_tdi", tdi_pack(h + 3, 11), {8'hA5, 3'h5});
    chk("single_update", tap[0].upd, {8'hA5, 3'h5});

    // Back-to-back frames
    cap_v[0] = 11'h1E6;
    h = tms_hist.size();
    req_valid0 = 1'b1; req_data0 = 8'h5A; req_addr0 = 3'h2;
    push_exp(cap_v[0]);
    t0 = cyc;
    wait_flag(1, 300, hit);
    chk("b2b_rsp1_seen", hit, 1);
    chk("b2b_latency1", cyc - t0, 129);
    chk("b2b_ready_at_rsp1", req_ready0, 1);
    check_rsp(0);
    chk("b2b_update1", tap[0].upd, {8'h5A, 3'h2});
    req_data0 = 8'hC3; req_addr0 = 3'h7;
    cap_v[0] = 11'h619;
    push_exp(cap_v[0]);
    t1 = cyc;
    @(negedge clk);
    req_valid0 = 1'b0;
    chk("b2b_accepted_at_rsp", req_ready0, 0);
    wait_flag(1, 300, hit);
    chk("b2b_rsp2_seen", hit, 1);
    chk("b2b_latency2", cyc - t1, 129);
    check_rsp(0);
    chk("b2b_slots", tms_hist.size() - h, 32);
    chk("b2b_tms2", tms_pack(h + 16, 16), DR_TMS);
    chk("b2b_tdi2", tdi_pack(h + 16 + 3, 11), {8'hC3, 3'h7});
    chk("b2b_update2", tap[0].upd, {8'hC3, 3'h7});

    // Reinit racing a request
    cap_v[0] = 11'h0AA;
    h = tms_hist.size();
    reinit0 = 1'b1; req_valid0 = 1'b1; req_data0 = 8'h81; req_addr0 = 3'h4;
    push_exp(cap_v[0]);
    @(negedge clk);
    reinit0 = 1'b0;
    chk("reinit_ready", req_ready0, 0);
    chk("reinit_done_clear", init_done0, 0);
    wait_flag(0, 400, hit);
    chk("reinit_done_seen", hit, 1);
    t0 = cyc;
    @(negedge clk);
    req_valid0 = 1'b0;
    wait_flag(1, 300, hit);
    chk("reinit_rsp_seen", hit, 1);
    chk("reinit_latency", cyc - t0, 129);
    check_rsp(0);
    chk("reinit_tms_init", tms_pack(h, 18), INIT_TMS);
    chk("reinit_tms_dr", tms_pack(h + 18, 16), DR_TMS);
    chk("reinit_update", tap[0].upd, {8'h81, 3'h4});

    // Reset in the middle of shift bit 5
    cap_v[0] = 11'h555;
    h = tms_hist.size();
    req_valid0 = 1'b1; req_data0 = 8'h3C; req_addr0 = 3'h3;
    @(negedge clk);
    req_valid0 = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (tms_hist.size() >= h + 9) begin
        hit = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("midscan_reached", hit, 1);
    chk("midscan_tck_high", tck_v[0], 1);
    rst = 1'b1;
    #1;
    chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    rel = cyc;
    h = tms_hist.size();
    wait_flag(0, 400, hit);
    chk("recover_init_seen", hit, 1);
    chk("recover_latency", cyc - rel, 144);
    chk("recover_tms", tms_pack(h, 18), INIT_TMS);
    chk("recover_tap_rti", tap[0].st, RTI);
    chk("recover_tap_ir", tap[0].ir, 6'h02);

    // CLK_DIV=1 frame
    chk("div1_init_done", init_done1, 1);
    cap_v[1] = 11'h2B4;
    req_valid1 = 1'b1; req_data1 = 8'h96; req_addr1 = 3'h1;
    push_exp(cap_v[1]);
    t0 = cyc;
    @(negedge clk);
    req_valid1 = 1'b0;
    pat[0] = tck_v[1];
    for (int j = 1; j < 8; j++) begin
      @(negedge clk);
      pat[j] = tck_v[1];
    end
    chk("div1_tck_toggle", pat, 8'hAA);
    wait_flag(2, 100, hit);
    chk("div1_rsp_seen", hit, 1);
    chk("div1_latency", cyc - t0, 33);
    check_rsp(1);
    chk("div1_update", tap[1].upd, {8'h96, 3'h1});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
